// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch-operand stall, control-flow flush and branch forwarding for a 5-stage pipeline
module hazard_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        IDEX_MemRead,
   input  logic        IDEX_RegWrite,
   input  logic [4:0]  IDEXRd,
   input  logic        EXMEM_MemRead,
   input  logic        EXMEM_RegWrite,
   input  logic [4:0]  EXMEMRd,
   input  logic [4:0]  IFIDRs,
   input  logic [4:0]  IFIDRt,
   input  logic        ID_UsesRt,
   input  logic        ID_Branch,
   input  logic        ID_BranchTaken,
   input  logic        ID_Jump,
   output logic        PC_Write,
   output logic        IFID_Write,
   output logic        IDEX_Bubble,
   output logic        IFID_Flush,
   output logic        ForwardBrA,
   output logic        ForwardBrB,
   output logic [15:0] StallCount,
   output logic [15:0] FlushCount
);
   typedef enum logic {RUN, HOLD} state_t;
   state_t state;
   logic   rem;
   logic   ld_rs, ld_rt, ex_rs, ex_rt, mld_rs, mld_rt, wb_rs, wb_rt;
   logic   need2, need1, stall;
   assign ld_rs  = IDEX_MemRead   && IFIDRs != 5'd0 && IFIDRs == IDEXRd;
   assign ld_rt  = IDEX_MemRead   && IFIDRt != 5'd0 && IFIDRt == IDEXRd;
   assign ex_rs  = IDEX_RegWrite  && IFIDRs != 5'd0 && IFIDRs == IDEXRd;
   assign ex_rt  = IDEX_RegWrite  && IFIDRt != 5'd0 && IFIDRt == IDEXRd;
   assign mld_rs = EXMEM_MemRead  && IFIDRs != 5'd0 && IFIDRs == EXMEMRd;
   assign mld_rt = EXMEM_MemRead  && IFIDRt != 5'd0 && IFIDRt == EXMEMRd;
   assign wb_rs  = EXMEM_RegWrite && IFIDRs != 5'd0 && IFIDRs == EXMEMRd;
   assign wb_rt  = EXMEM_RegWrite && IFIDRt != 5'd0 && IFIDRt == EXMEMRd;
   assign need2 = ID_Branch && (ld_rs || ld_rt);
   assign need1 = ld_rs || (ld_rt && ID_UsesRt) || (ID_Branch && (ex_rs || ex_rt || mld_rs || mld_rt));
   // rst_n gates the combinational outputs so reset takes effect without a clock edge
   assign stall       = rst_n && (state == HOLD || need2 || need1);
   assign PC_Write    = !stall;
   assign IFID_Write  = !stall;
   assign IDEX_Bubble = stall;
   assign IFID_Flush  = rst_n && (ID_BranchTaken || ID_Jump) && !stall;
   assign ForwardBrA  = rst_n && ID_Branch && wb_rs && !EXMEM_MemRead;
   assign ForwardBrB  = rst_n && ID_Branch && wb_rt && !EXMEM_MemRead;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         rem        <= 1'b0;
         StallCount <= 16'd0;
         FlushCount <= 16'd0;
      end else begin
         if (state == RUN) begin
            if (need2) begin
               state <= HOLD;
               rem   <= 1'b0;
            end
         end else if (rem) rem <= 1'b0;
         else state <= RUN;
         if (stall && StallCount != 16'hFFFF) StallCount <= StallCount + 16'd1;
         if (IFID_Flush && FlushCount != 16'hFFFF) FlushCount <= FlushCount + 16'd1;
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table plus multi-cycle sequences for hazard_ctrl
`timescale 1ns/1ps
module tb_hazard_ctrl;
   typedef struct packed {
      logic       ldx, rwx;
      logic [4:0] rdx;
      logic       ldm, rwm;
      logic [4:0] rdm, rs, rt;
      logic       urt, br, bt, j;
   } in_t;
   typedef struct packed {
      in_t        i;
      logic [5:0] e;
   } vec_t;
   logic clk = 1'b0, rst_n = 1'b0;
   logic IDEX_MemRead, IDEX_RegWrite, EXMEM_MemRead, EXMEM_RegWrite;
   logic [4:0] IDEXRd, EXMEMRd, IFIDRs, IFIDRt;
   logic ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump;
   logic PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, ForwardBrA, ForwardBrB;
   logic [15:0] StallCount, FlushCount;
   int checks = 0, errors = 0;
   vec_t tq[$];
   hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite), .IDEXRd(IDEXRd),
      .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_RegWrite(EXMEM_RegWrite), .EXMEMRd(EXMEMRd),
      .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .ID_UsesRt(ID_UsesRt), .ID_Branch(ID_Branch),
      .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump),
      .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IDEX_Bubble(IDEX_Bubble),
      .IFID_Flush(IFID_Flush), .ForwardBrA(ForwardBrA), .ForwardBrB(ForwardBrB),
      .StallCount(StallCount), .FlushCount(FlushCount)
   );
   always #5 clk = ~clk;
   task automatic apply(input in_t v);
      IDEX_MemRead = v.ldx; IDEX_RegWrite = v.rwx; IDEXRd = v.rdx;
      EXMEM_MemRead = v.ldm; EXMEM_RegWrite = v.rwm; EXMEMRd = v.rdm;
      IFIDRs = v.rs; IFIDRt = v.rt; ID_UsesRt = v.urt;
      ID_Branch = v.br; ID_BranchTaken = v.bt; ID_Jump = v.j;
   endtask
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic logic [5:0] outs();
      return {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, ForwardBrA, ForwardBrB};
   endfunction
   task automatic do_reset();
      rst_n = 1'b0;
      apply('0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic add(input in_t i, input logic [5:0] e);
      tq.push_back('{i: i, e: e});
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
   initial begin
      in_t ld2, brld3;
      ld2   = '{ldx: 1'b1, rdx: 5'd2, rs: 5'd2, default: '0};
      brld3 = '{ldx: 1'b1, rwx: 1'b1, rdx: 5'd3, rt: 5'd3, urt: 1'b1, br: 1'b1, default: '0};
      // outputs: {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, ForwardBrA, ForwardBrB}
      add('0, 6'b110000);
      add(ld2, 6'b001000);
      add('{ldx: 1'b1, rdx: 5'd2, rt: 5'd2, default: '0}, 6'b110000);
      add('{ldx: 1'b1, rdx: 5'd2, rt: 5'd2, urt: 1'b1, default: '0}, 6'b001000);
      add('{ldx: 1'b1, default: '0}, 6'b110000);
      add('{rwx: 1'b1, rdx: 5'd5, rs: 5'd5, br: 1'b1, default: '0}, 6'b001000);
      add('{ldm: 1'b1, rwm: 1'b1, rdm: 5'd6, rt: 5'd6, br: 1'b1, default: '0}, 6'b001000);
      add('{rwm: 1'b1, rdm: 5'd4, rs: 5'd4, br: 1'b1, default: '0}, 6'b110010);
      add('{rwm: 1'b1, br: 1'b1, default: '0}, 6'b110000);
      add('{rwm: 1'b1, rdm: 5'd7, rt: 5'd7, br: 1'b1, default: '0}, 6'b110001);
      add('{j: 1'b1, default: '0}, 6'b110100);
      add('{ldx: 1'b1, rdx: 5'd2, rs: 5'd2, bt: 1'b1, default: '0}, 6'b001000);
      add('{rwx: 1'b1, rdx: 5'd5, rs: 5'd5, default: '0}, 6'b110000);
      add('{rwx: 1'b1, rdx: 5'd9, rs: 5'd9, br: 1'b1, bt: 1'b1, default: '0}, 6'b001000);
      add('{rwm: 1'b1, rdm: 5'd4, rs: 5'd4, br: 1'b1, bt: 1'b1, default: '0}, 6'b110110);
      do_reset();
      foreach (tq[k]) begin
         apply(tq[k].i);
         #1 check($sformatf("vec%0d", k), 32'(outs()), 32'(tq[k].e));
         @(negedge clk);
      end
      // single-cycle load-use stall
      do_reset();
      #1 check("rst_stallcnt", 32'(StallCount), 0);
      check("rst_flushcnt", 32'(FlushCount), 0);
      check("rst_outs", 32'(outs()), 32'(6'b110000));
      apply(ld2);
      #1 check("lu_stall", 32'(outs()), 32'(6'b001000));
      @(negedge clk);
      apply('0);
      #1 check("lu_release", 32'(PC_Write), 1);
      check("lu_stallcnt", 32'(StallCount), 1);
      // branch on a load result: RUN stall then HOLD stall, HOLD ignores new inputs
      do_reset();
      apply(brld3);
      #1 check("br2_c1", 32'(outs()), 32'(6'b001000));
      @(negedge clk);
      apply('{j: 1'b1, default: '0});
      #1 check("br2_c2", 32'(outs()), 32'(6'b001000));
      @(negedge clk);
      apply('0);
      #1 check("br2_done", 32'(outs()), 32'(6'b110000));
      check("br2_stallcnt", 32'(StallCount), 2);
      check("br2_flushcnt", 32'(FlushCount), 0);
      // jump flush, then taken branch suppressed by a load-use stall
      do_reset();
      apply('{j: 1'b1, default: '0});
      #1 check("jmp_flush", 32'(IFID_Flush), 1);
      @(negedge clk);
      apply('0);
      #1 check("jmp_noflush", 32'(IFID_Flush), 0);
      check("jmp_flushcnt", 32'(FlushCount), 1);
      apply('{ldx: 1'b1, rdx: 5'd2, rs: 5'd2, bt: 1'b1, default: '0});
      #1 check("bt_lu", 32'(outs()), 32'(6'b001000));
      @(negedge clk);
      apply('0);
      #1 check("bt_lu_flushcnt", 32'(FlushCount), 1);
      // asynchronous reset in HOLD
      do_reset();
      apply(brld3);
      @(negedge clk);
      apply('0);
      #1 check("hold_stall", 32'(PC_Write), 0);
      rst_n = 1'b0;
      #1 check("async_outs", 32'(outs()), 32'(6'b110000));
      check("async_stallcnt", 32'(StallCount), 0);
      apply('{rwm: 1'b1, rdm: 5'd4, rs: 5'd4, br: 1'b1, default: '0});
      #1 check("rst_nofwd", 32'(outs()), 32'(6'b110000));
      apply('0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("post_rst_c1", 32'(outs()), 32'(6'b110000));
      @(negedge clk);
      #1 check("post_rst_c2", 32'(outs()), 32'(6'b110000));
      check("post_rst_cnt", 32'(StallCount), 0);
      // StallCount saturation under sustained stall
      do_reset();
      apply(ld2);
      repeat (65534) @(posedge clk);
      @(negedge clk);
      #1 check("sat_fffe", 32'(StallCount), 32'hFFFE);
      @(negedge clk);
      #1 check("sat_ffff", 32'(StallCount), 32'hFFFF);
      repeat (3) @(negedge clk);
      #1 check("sat_hold", 32'(StallCount), 32'hFFFF);
      apply('0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
